banco_registradores: RTL and testbench
======================================

Name: banco_registradores

Overview:
- Parameterised multi-entry register file built from load-enabled storage words. It generalises the single load-enable register to DEPTH words with two combinational read ports and one synchronous write port.
- It is the CPU's general-purpose register bank. The datapath reads rs/rt in decode, and a result from ALUOut/MDR is written back under RegWrite.
- Adds a hardwired zero register, a configurable stack-pointer reset value, and optional write-to-read bypass.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 32, number of registers (power of two, >=2).
- ADDR_W, 5, index width; must equal log2(DEPTH).
- SP_INDEX, 29, index of the stack-pointer register.
- SP_RESET, 227, reset value of register SP_INDEX (WIDTH bits, zero-extended).
- BYPASS, 0, 1 = same-cycle write data forwarded to read ports.

Ports:
- clk  input  1  clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- RegWrite  input  1  write enable, sampled on rising clk.
- ReadReg1  input  ADDR_W  read port 1 index.
- ReadReg2  input  ADDR_W  read port 2 index.
- WriteReg  input  ADDR_W  write index.
- WriteData  input  WIDTH  write data.
- ReadData1  output  WIDTH  contents of ReadReg1.
- ReadData2  output  WIDTH  contents of ReadReg2.

Behaviour:
- Storage: DEPTH words of WIDTH bits. Clock is clk; reset is reset, asynchronous, active-high.
- Reset: while reset=1, every register is 0 except register SP_INDEX, which is SP_RESET. Reset takes effect immediately, without waiting for a clk edge.
- Reset dominates: a write coincident with reset is discarded. After reset deasserts, the first rising edge with RegWrite=1 performs a normal write.
- Write: on rising clk with reset=0 and RegWrite=1, reg[WriteReg] <= WriteData. Latency is 1 edge; the value is visible at the read ports after that edge.
- Register 0: writes to index 0 are ignored. Reads of index 0 always return 0, independent of BYPASS.
- SP register: an ordinary register after reset, fully writable.
- Reads: combinational with zero latency. ReadDataN = reg[ReadRegN]. Outputs track address changes within the same cycle.
- Both read ports may address the same register simultaneously and return identical data.
- BYPASS=0: a read of the register being written this cycle returns the old value until the edge.
- BYPASS=1: if RegWrite=1, reset=0, WriteReg!=0 and ReadRegN==WriteReg, then ReadDataN = WriteData in the same cycle. Both ports bypass independently.
- Output values during reset: ReadDataN returns reset contents, i.e. 0, or SP_RESET for SP_INDEX.
- Width rules: no arithmetic. WriteData is stored unmodified. SP_RESET is truncated to WIDTH if wider.
- RegWrite=0: no register changes, regardless of WriteReg/WriteData.
- X-safety: an unknown WriteReg while RegWrite=0 must not corrupt any register.

Test Plan:
- Reset values: assert reset mid-cycle, no clk edge -> ReadData1 (ReadReg1=29) = 227 immediately; ReadData2 (ReadReg2=5) = 0.
- Write/read: RegWrite=1, WriteReg=8, WriteData=0xDEADBEEF, one edge. Then ReadReg1=8, ReadReg2=8 -> both ports read 0xDEADBEEF. With BYPASS=0, before the edge ReadData1 = 0.
- Zero register: RegWrite=1, WriteReg=0, WriteData=0xFFFFFFFF, edge -> ReadReg1=0 reads 0, both with BYPASS=0 and BYPASS=1.
- Bypass: BYPASS=1, RegWrite=1, WriteReg=12, WriteData=0x1234, ReadReg1=12 -> ReadData1 = 0x1234 in the same cycle, before the edge.
- Reset mid-operation: reg[29] written to 0x100. Then reset pulses coincident with RegWrite=1, WriteReg=3, WriteData=7 -> reg[29] = 227 and reg[3] = 0. The next edge after release with the same inputs gives reg[3] = 7.
- Enable gating: RegWrite=0, WriteReg=4, WriteData=0x55, 3 edges -> reg[4] unchanged at 0. Also sweep all 32 indices writing index*3 and read back each via both ports.

Source files
------------

// File: rtl/banco_registradores.sv
// ============================================================================
// banco_registradores
// ----------------------------------------------------------------------------
// General-purpose register bank of the CPU datapath. Holds DEPTH words of
// WIDTH bits. It has two combinational read ports (rs/rt in decode) and one
// synchronous write port (write-back of ALUOut/MDR under RegWrite).
//
// Features:
//   - Register 0 is hardwired to zero. Writes to it are dropped, and reads of
//     it return 0 even when bypass is enabled.
//   - Register SP_INDEX resets to SP_RESET. After reset it behaves as an
//     ordinary register.
//   - When BYPASS=1, write data is forwarded to a read port that addresses
//     the register being written in the same cycle.
//
// Ports:
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high reset
//   RegWrite   in   1       write enable, sampled on rising clk
//   ReadReg1   in   ADDR_W  read port 1 index
//   ReadReg2   in   ADDR_W  read port 2 index
//   WriteReg   in   ADDR_W  write index
//   WriteData  in   WIDTH   write data
//   ReadData1  out  WIDTH   contents of ReadReg1
//   ReadData2  out  WIDTH   contents of ReadReg2
// ============================================================================
module banco_registradores #(
    parameter int              WIDTH    = 32,
    parameter int              DEPTH    = 32,
    parameter int              ADDR_W   = 5,
    parameter int              SP_INDEX = 29,
    parameter longint unsigned SP_RESET = 227,
    parameter bit              BYPASS   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [WIDTH-1:0]  WriteData,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);

    // Reset value of the stack pointer. The cast zero-extends or truncates
    // it to WIDTH.
    localparam logic [WIDTH-1:0] SP_INIT = WIDTH'(SP_RESET);

    logic [WIDTH-1:0] regs [DEPTH];

    // A write is forwardable only when it will actually land in storage.
    // That excludes writes during reset and writes to the zero register.
    logic wr_fwd;

    assign wr_fwd = RegWrite && !reset && (WriteReg != '0);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // Each word is decoded against its own index, so a word is written only
    // when RegWrite is 1. An unknown WriteReg while RegWrite is 0 therefore
    // cannot reach any word. Word 0 is only ever loaded by reset, which
    // keeps it at constant zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == SP_INDEX && i != 0)
                    regs[i] <= SP_INIT;
                else
                    regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (RegWrite && (WriteReg == ADDR_W'(i)))
                    regs[i] <= WriteData;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    // The index-0 test comes first, so the zero register wins over bypass.
    // During reset the storage already holds its reset contents
    // asynchronously, and wr_fwd is low, so the ports show reset values.
    always_comb begin
        ReadData1 = regs[ReadReg1];
        if (ReadReg1 == '0)
            ReadData1 = '0;
        else if (BYPASS && wr_fwd && (ReadReg1 == WriteReg))
            ReadData1 = WriteData;
    end

    always_comb begin
        ReadData2 = regs[ReadReg2];
        if (ReadReg2 == '0)
            ReadData2 = '0;
        else if (BYPASS && wr_fwd && (ReadReg2 == WriteReg))
            ReadData2 = WriteData;
    end

endmodule

// File: tb/tb_banco_registradores.sv
// ============================================================================
// tb_banco_registradores
// ----------------------------------------------------------------------------
// Bench for banco_registradores. Two instances share all inputs: one is
// built with BYPASS=0 and the other with BYPASS=1. A reference register
// model produces the expected read data. Expected values are pushed to a
// scoreboard queue when stimulus is driven, then popped and compared once
// the outputs have settled.
// ============================================================================
module tb_banco_registradores;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        RegWrite  = 1'b0;
    logic [4:0]  ReadReg1  = '0;
    logic [4:0]  ReadReg2  = '0;
    logic [4:0]  WriteReg  = '0;
    logic [31:0] WriteData = '0;

    logic [31:0] rd1_nb, rd2_nb, rd1_by, rd2_by;

    banco_registradores #(
        .WIDTH(32), .DEPTH(32), .ADDR_W(5), .SP_INDEX(29), .SP_RESET(227), .BYPASS(1'b0)
    ) u_nobyp (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadData1(rd1_nb), .ReadData2(rd2_nb)
    );

    banco_registradores #(
        .WIDTH(32), .DEPTH(32), .ADDR_W(5), .SP_INDEX(29), .SP_RESET(227), .BYPASS(1'b1)
    ) u_byp (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadData1(rd1_by), .ReadData2(rd2_by)
    );

    always #5 clk = ~clk;

    // Reference register model
    logic [31:0] mdl [32];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        int          sel;   // 0: nb port1, 1: nb port2, 2: byp port1, 3: byp port2
        logic [31:0] exp;
    } item_t;

    item_t sb[$];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mdl[29] = 32'd227;
    endtask

    function automatic logic [31:0] exp_rd(bit byp, logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (byp && RegWrite && !reset && (WriteReg != 5'd0) && (WriteReg == a)) return WriteData;
        return mdl[a];
    endfunction

    function automatic logic [31:0] observed(int sel);
        case (sel)
            0:       return rd1_nb;
            1:       return rd2_nb;
            2:       return rd1_by;
            default: return rd2_by;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Queue the expected values for all four read ports under the current inputs.
    task automatic expect_ports(input string tag);
        item_t it;
        it.tag = {tag, "_nb_rd1"}; it.sel = 0; it.exp = exp_rd(1'b0, ReadReg1); sb.push_back(it);
        it.tag = {tag, "_nb_rd2"}; it.sel = 1; it.exp = exp_rd(1'b0, ReadReg2); sb.push_back(it);
        it.tag = {tag, "_by_rd1"}; it.sel = 2; it.exp = exp_rd(1'b1, ReadReg1); sb.push_back(it);
        it.tag = {tag, "_by_rd2"}; it.sel = 3; it.exp = exp_rd(1'b1, ReadReg2); sb.push_back(it);
    endtask

    task automatic drain();
        item_t it;
        #1;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            check(it.tag, observed(it.sel), it.exp);
        end
    endtask

    // Check the ports before any clock edge.
    task automatic pre(input string tag);
        expect_ports(tag);
        drain();
    endtask

    // Apply one rising edge, update the model, check, then return at the
    // next falling edge, ready for new stimulus.
    task automatic step(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else if (RegWrite && (WriteReg != 5'd0)) mdl[WriteReg] = WriteData;
        expect_ports(tag);
        drain();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;

        // Asynchronous reset, asserted before the first clock edge
        #2;
        reset = 1'b1; ReadReg1 = 5'd29; ReadReg2 = 5'd5;
        model_reset();
        drain();
        check("rst_sp_const",   rd1_nb, 32'd227);
        check("rst_zero_const", rd2_nb, 32'd0);
        pre("rst_async");
        @(negedge clk);
        reset = 1'b0;

        // Basic write/read, with the value before the edge shown both ways
        RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF;
        ReadReg1 = 5'd8; ReadReg2 = 5'd8;
        pre("wr8_pre");
        step("wr8_post");
        RegWrite = 1'b0;
        pre("wr8_hold");

        // Writes to the zero register are dropped
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF;
        ReadReg1 = 5'd0; ReadReg2 = 5'd8;
        pre("zero_pre");
        step("zero_post");

        // Same-cycle forwarding
        WriteReg = 5'd12; WriteData = 32'h0000_1234;
        ReadReg1 = 5'd12; ReadReg2 = 5'd12;
        pre("byp12_pre");
        step("byp12_post");

        // SP is writable, then reset hits mid-operation
        WriteReg = 5'd29; WriteData = 32'h0000_0100;
        ReadReg1 = 5'd29; ReadReg2 = 5'd3;
        step("sp_wr");
        WriteReg = 5'd3; WriteData = 32'd7; reset = 1'b1;
        model_reset();
        pre("rst_mid");
        step("rst_mid_edge");
        reset = 1'b0;
        pre("rel_pre");
        step("rel_edge");

        // Enable gating: nothing changes with RegWrite low
        RegWrite = 1'b0; WriteReg = 5'd4; WriteData = 32'h55;
        ReadReg1 = 5'd4; ReadReg2 = 5'd4;
        repeat (3) step("gate");

        // An unknown write index with RegWrite low must not corrupt storage
        WriteReg = 'x; ReadReg1 = 5'd8; ReadReg2 = 5'd3;
        step("xsafe");
        WriteReg = 5'd0;

        // Sweep: write index*3 to every register, then read each one back
        // through both ports
        RegWrite = 1'b1;
        for (int i = 0; i < 32; i++) begin
            WriteReg = 5'(i); WriteData = 32'(i * 3);
            ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
            step("sweep_wr");
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
            pre("sweep_rd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
